ialm_seq: RTL
=============

IALM_SEQ -- requirements
Module: ialm_seq

Interface
REQ-001 Parameter N, default 16, operand width in bits (4..32).
REQ-002 Parameter MAX_ITER, default 4, maximum iterative-log refinement stages per product (1..8).
REQ-003 Parameter IW, default $clog2(MAX_ITER+1), width of iteration-count ports.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand transaction offered.
REQ-007 in_ready  output  1  block can accept a transaction.
REQ-008 a, b  input  N each  unsigned operands.
REQ-009 iter_num  input  IW  requested iteration count for this transaction.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  2N  approximate unsigned product.
REQ-013 iter_used  output  IW  iterations actually executed.

Function
REQ-014 Handshake: accept when in_valid && in_ready; deliver when out_valid && out_ready; a, b, iter_num are sampled only on accept.
REQ-015 FSM states: IDLE, CALC, DONE; IDLE->CALC on accept; CALC->DONE on termination; DONE->IDLE on delivery.
REQ-016 in_ready = 1 only in IDLE; out_valid = 1 only in DONE; a single transaction is in flight.
REQ-017 Effective count E = 1 if iter_num==0, MAX_ITER if iter_num>MAX_ITER, else iter_num.
REQ-018 Each CALC cycle performs one stage on residuals (x, y): k1 = leading-one index of x, k2 = leading-one index of y, r1 = x-2^k1, r2 = y-2^k2; acc += 2^(k1+k2) + r1*2^k2 + r2*2^k1; then x<=r1, y<=r2, count++.
REQ-019 If x==0 or y==0 at the start of a CALC cycle, no term is added and the state moves to DONE.
REQ-020 The state also moves to DONE after the cycle in which count reaches E.
REQ-021 result = acc; iter_used = count; both are held stable while in DONE.
REQ-022 The 2N-bit accumulator never overflows, because each partial sum is <= a*b; no saturation logic.
REQ-023 Latency: out_valid rises max(iter_used,1) + 1 cycles after the accept edge; either zero operand gives result 0, iter_used 0, and latency 2.
REQ-024 Back-pressure: while out_ready=0, DONE is held indefinitely with outputs unchanged.
REQ-025 in_valid in CALC or DONE is ignored and does not change state.
REQ-026 When out_ready=1 in DONE, the block returns to IDLE on the next edge; a new accept can happen no earlier than the following edge.

Reset
REQ-027 rst takes priority over all other inputs and forces state IDLE, acc 0, count 0, and x, y 0.
REQ-028 Output reset values: in_ready 1, out_valid 0, result 0, iter_used 0.
REQ-029 rst asserted in CALC or DONE aborts the transaction silently; no partial result is ever presented.

Structure
REQ-030 Shared package ialm_pkg holds the FSM state enum and the leading-one/clog2 helper functions.
REQ-031 Sub-module ialm_stage (combinational) takes x, y and returns the term, r1, r2, and a zero flag.
REQ-032 ialm_stage has a single instance, reused every CALC cycle.

Verification
REQ-033 N=16, a=0xFFFF, b=0xFFFF, iter_num=1 -> result 0xBFFF0000, iter_used 1, latency 2.
REQ-034 Same operands, iter_num=2 -> result 0xEFFE8000, iter_used 2, latency 3.
REQ-035 a=3, b=5, iter_num=4 -> result 15 (exact), iter_used 2 (early stop on zero residual).
REQ-036 a=0, b=1234, iter_num=3 -> result 0, iter_used 0, latency 2.
REQ-037 Hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> outputs stable, in_ready 0, no second accept.
REQ-038 Assert rst in the second CALC cycle -> the next cycle shows in_ready 1, out_valid 0, result 0, and no spurious out_valid follows.

Source files
------------

// File: rtl/ialm_pkg.sv
// Shared definitions for the iterative-log approximate multiplier:
// sequencer state encoding and bit-scan helpers.
package ialm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Index of the most significant set bit; returns 0 for a zero input.
   function automatic logic [4:0] lead_one(input logic [31:0] v);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) idx = 5'(i);
      end
      return idx;
   endfunction

   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/ialm_stage.sv
// One iterative-log refinement stage: splits each residual into its leading
// power of two and remainder, and forms the partial product term.
module ialm_stage
   import ialm_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [N-1:0]   x,
   input  logic [N-1:0]   y,
   output logic [2*N-1:0] term,
   output logic [N-1:0]   r1,
   output logic [N-1:0]   r2,
   output logic           zero
);

   logic [31:0]    x_ext, y_ext;
   logic [4:0]     k1, k2;
   logic [5:0]     k_sum;
   logic [2*N-1:0] r1_w, r2_w;

   always_comb begin
      x_ext        = '0;
      y_ext        = '0;
      x_ext[N-1:0] = x;
      y_ext[N-1:0] = y;
      k1           = lead_one(x_ext);
      k2           = lead_one(y_ext);
      k_sum        = {1'b0, k1} + {1'b0, k2};
      r1           = x & ~(N'(1) << k1);
      r2           = y & ~(N'(1) << k2);
      r1_w         = '0;
      r2_w         = '0;
      r1_w[N-1:0]  = r1;
      r2_w[N-1:0]  = r2;
      // 2^(k1+k2) + r1*2^k2 + r2*2^k1 never exceeds x*y, so 2N bits suffice
      term         = ((2*N)'(1) << k_sum) + (r1_w << k2) + (r2_w << k1);
      zero         = (x == '0) || (y == '0);
   end

endmodule

// File: rtl/ialm_seq.sv
// Iterative-log approximate multiplier sequencer: one transaction in flight,
// one refinement stage per CALC cycle using a single shared stage instance.
//
//   state | meaning
//   IDLE  | ready for a new operand pair
//   CALC  | one refinement stage per cycle until count limit or zero residual
//   DONE  | result held until the consumer accepts it
module ialm_seq
   import ialm_pkg::*;
#(
   parameter int N        = 16,
   parameter int MAX_ITER = 4,
   parameter int IW       = clog2_f(MAX_ITER + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic [IW-1:0]  iter_num,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] result,
   output logic [IW-1:0]  iter_used
);

   state_t         state, state_nx;
   logic [N-1:0]   x, y;
   logic [2*N-1:0] acc;
   logic [IW-1:0]  count, eff, eff_in;
   logic [2*N-1:0] term;
   logic [N-1:0]   r1, r2;
   logic           zero, last;

   ialm_stage #(.N(N)) u_stage (
      .x    (x),
      .y    (y),
      .term (term),
      .r1   (r1),
      .r2   (r2),
      .zero (zero)
   );

   always_comb begin
      eff_in = iter_num;
      if (iter_num == '0)
         eff_in = IW'(1);
      else if (iter_num > IW'(MAX_ITER))
         eff_in = IW'(MAX_ITER);
   end

   // Stopping as soon as a residual hits zero keeps latency at count+1;
   // any further stage would add nothing to the accumulator.
   assign last = ((count + IW'(1)) == eff) || (r1 == '0) || (r2 == '0);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (in_valid) state_nx = CALC;
         CALC:    if (zero || last) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         x     <= '0;
         y     <= '0;
         acc   <= '0;
         count <= '0;
         eff   <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && in_valid) begin
            x     <= a;
            y     <= b;
            acc   <= '0;
            count <= '0;
            eff   <= eff_in;
         end else if (state == CALC && !zero) begin
            acc   <= acc + term;
            x     <= r1;
            y     <= r2;
            count <= count + IW'(1);
         end
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign result    = acc;
   assign iter_used = count;

endmodule
